// File: rtl/csr_trap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : csr_trap_ctrl
//  Brief    : Machine-mode trap entry / MRET sequencer. It arbitrates the
//             single CSR file port between the pipeline and a fixed
//             multi-cycle trap/return microsequence. It also issues the
//             fetch redirect at the end of each sequence.
//  Revision : 1.0 - initial release
// ============================================================================
module csr_trap_ctrl #(
    parameter int WIDTH = 32,
    parameter int AW    = 12
) (
    input  logic             clock,
    input  logic             reset,

    // trap / return requests (held by the requester until acknowledged)
    input  logic             trap_req,
    input  logic [WIDTH-1:0] trap_pc,
    input  logic [WIDTH-1:0] trap_cause,
    input  logic [WIDTH-1:0] trap_val,
    input  logic             mret_req,
    output logic             trap_ack,
    output logic             mret_ack,

    // pipeline CSR instruction port
    input  logic             pipe_csr,
    input  logic             pipe_csrsc,
    input  logic [4:0]       pipe_rs1,
    input  logic [AW-1:0]    pipe_addr,
    input  logic [WIDTH-1:0] pipe_wdata,
    output logic [WIDTH-1:0] pipe_rdata,

    // CSR file port (combinational read, write on the clock edge)
    output logic             csr_we,
    output logic [AW-1:0]    csr_addr,
    output logic [WIDTH-1:0] csr_wdata,
    input  logic [WIDTH-1:0] csr_rdata,

    // pipeline control
    output logic             busy,
    output logic             redirect_valid,
    output logic [WIDTH-1:0] redirect_pc
);

    // Machine-mode CSR addresses touched by the sequencer
    localparam logic [AW-1:0] c_addr_mstatus = AW'(12'h300);
    localparam logic [AW-1:0] c_addr_mtvec   = AW'(12'h305);
    localparam logic [AW-1:0] c_addr_mepc    = AW'(12'h341);
    localparam logic [AW-1:0] c_addr_mcause  = AW'(12'h342);
    localparam logic [AW-1:0] c_addr_mtval   = AW'(12'h343);

    // Explicitly encoded sequencer states; every non-IDLE state lasts one cycle
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        T_EPC    = 3'd1,
        T_CAUSE  = 3'd2,
        T_TVAL   = 3'd3,
        T_STATUS = 3'd4,
        T_VEC    = 3'd5,
        M_STATUS = 3'd6,
        M_EPC    = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q,    pc_d;
    logic [WIDTH-1:0] cause_q, cause_d;
    logic [WIDTH-1:0] val_q,   val_d;

    logic [WIDTH-1:0] w_status_trap;
    logic [WIDTH-1:0] w_status_mret;
    logic [WIDTH-1:0] w_vec_base;
    logic [WIDTH-1:0] w_vec_offset;
    logic [WIDTH-1:0] w_vec_pc;
    logic [WIDTH-1:0] w_mepc_pc;
    logic             w_pipe_we;

    // mstatus rewrite on trap entry: MPIE<=MIE, MIE<=0, MPP<=M
    function automatic logic [WIDTH-1:0] status_on_trap(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] r;
        r        = s;
        r[7]     = s[3];
        r[3]     = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    // mstatus rewrite on MRET: MIE<=MPIE, MPIE<=1, MPP<=U
    function automatic logic [WIDTH-1:0] status_on_mret(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] r;
        r        = s;
        r[3]     = s[7];
        r[7]     = 1'b1;
        r[12:11] = 2'b00;
        return r;
    endfunction

    // Datapath helpers derived from whatever the CSR file currently returns
    always_comb begin
        w_status_trap = status_on_trap(csr_rdata);
        w_status_mret = status_on_mret(csr_rdata);
        w_vec_base    = {csr_rdata[WIDTH-1:2], 2'b00};
        // cause[W-2:0] << 2 truncated to WIDTH bits: bit W-2 shifts out
        w_vec_offset  = {cause_q[WIDTH-3:0], 2'b00};
        w_vec_pc      = ((csr_rdata[1:0] == 2'b01) && cause_q[WIDTH-1])
                        ? (w_vec_base + w_vec_offset) : w_vec_base;
        w_mepc_pc     = {csr_rdata[WIDTH-1:2], 2'b00};
        // set/clear forms with rs1 == x0 are pure reads
        w_pipe_we     = pipe_csr && (!pipe_csrsc || (pipe_rs1 != 5'd0));
    end

    // Next-state, request latching and CSR port / redirect outputs
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        cause_d        = cause_q;
        val_d          = val_q;
        trap_ack       = 1'b0;
        mret_ack       = 1'b0;
        csr_we         = 1'b0;
        csr_addr       = '0;
        csr_wdata      = '0;
        pipe_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        case (state_q)
            IDLE: begin
                csr_addr   = pipe_addr;
                csr_wdata  = pipe_wdata;
                pipe_rdata = csr_rdata;
                csr_we     = w_pipe_we;
                if (trap_req) begin
                    // trap wins over a simultaneous MRET, which stays pending
                    trap_ack = 1'b1;
                    csr_we   = 1'b0;
                    pc_d     = trap_pc;
                    cause_d  = trap_cause;
                    val_d    = trap_val;
                    state_d  = T_EPC;
                end else if (mret_req) begin
                    mret_ack = 1'b1;
                    csr_we   = 1'b0;
                    state_d  = M_STATUS;
                end
            end
            T_EPC: begin
                csr_we    = 1'b1;
                csr_addr  = c_addr_mepc;
                csr_wdata = pc_q;
                state_d   = T_CAUSE;
            end
            T_CAUSE: begin
                csr_we    = 1'b1;
                csr_addr  = c_addr_mcause;
                csr_wdata = cause_q;
                state_d   = T_TVAL;
            end
            T_TVAL: begin
                csr_we    = 1'b1;
                csr_addr  = c_addr_mtval;
                csr_wdata = val_q;
                state_d   = T_STATUS;
            end
            T_STATUS: begin
                // read-modify-write through the combinational read path
                csr_we    = 1'b1;
                csr_addr  = c_addr_mstatus;
                csr_wdata = w_status_trap;
                state_d   = T_VEC;
            end
            T_VEC: begin
                csr_addr       = c_addr_mtvec;
                redirect_valid = 1'b1;
                redirect_pc    = w_vec_pc;
                state_d        = IDLE;
            end
            M_STATUS: begin
                csr_we    = 1'b1;
                csr_addr  = c_addr_mstatus;
                csr_wdata = w_status_mret;
                state_d   = M_EPC;
            end
            M_EPC: begin
                csr_addr       = c_addr_mepc;
                redirect_valid = 1'b1;
                redirect_pc    = w_mepc_pc;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // While reset is asserted nothing may be committed or acknowledged,
        // so an interrupted sequence performs no further CSR write.
        if (reset) begin
            trap_ack       = 1'b0;
            mret_ack       = 1'b0;
            csr_we         = 1'b0;
            redirect_valid = 1'b0;
            redirect_pc    = '0;
        end
    end

    // State and latched trap information registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cause_q <= '0;
            val_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cause_q <= cause_d;
            val_q   <= val_d;
        end
    end

    // Pipeline stalls for the whole microsequence
    assign busy = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_csr_trap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_csr_trap_ctrl
//  Brief    : Self-checking bench for csr_trap_ctrl with a behavioural CSR
//             file and an architectural reference model of trap/MRET effects.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_csr_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        trap_req, mret_req, trap_ack, mret_ack;
    logic [31:0] trap_pc, trap_cause, trap_val;
    logic        pipe_csr, pipe_csrsc;
    logic [4:0]  pipe_rs1;
    logic [11:0] pipe_addr;
    logic [31:0] pipe_wdata, pipe_rdata;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, csr_rdata;
    logic        busy, redirect_valid;
    logic [31:0] redirect_pc;

    // CSR file seen by the DUT, and the bench's architectural expectation of it
    logic [31:0] csr_mem   [0:4095] = '{default: 32'h0};
    logic [31:0] model_mem [0:4095];
    logic [11:0] addr_set  [0:9] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342,
                                     12'h343, 12'h7C0, 12'h7C1, 12'h7C2, 12'h7C3};

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] last_redirect;

    csr_trap_ctrl #(.WIDTH(32), .AW(12)) dut (
        .clock          (clk),
        .reset          (rst),
        .trap_req       (trap_req),
        .trap_pc        (trap_pc),
        .trap_cause     (trap_cause),
        .trap_val       (trap_val),
        .mret_req       (mret_req),
        .trap_ack       (trap_ack),
        .mret_ack       (mret_ack),
        .pipe_csr       (pipe_csr),
        .pipe_csrsc     (pipe_csrsc),
        .pipe_rs1       (pipe_rs1),
        .pipe_addr      (pipe_addr),
        .pipe_wdata     (pipe_wdata),
        .pipe_rdata     (pipe_rdata),
        .csr_we         (csr_we),
        .csr_addr       (csr_addr),
        .csr_wdata      (csr_wdata),
        .csr_rdata      (csr_rdata),
        .busy           (busy),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    // Behavioural CSR file: combinational read, write on rising edge
    always @(posedge clk) begin
        if (csr_we) csr_mem[csr_addr] <= csr_wdata;
    end
    assign csr_rdata = csr_mem[csr_addr];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        trap_req = 0; mret_req = 0; pipe_csr = 0; pipe_csrsc = 0; pipe_rs1 = 0;
        pipe_addr = 0; pipe_wdata = 0; trap_pc = 0; trap_cause = 0; trap_val = 0;
    endtask

    // Junk pipeline traffic while the sequencer owns the CSR port
    task automatic random_pipe();
        pipe_csr   = 1'($urandom_range(0, 1));
        pipe_csrsc = 1'($urandom_range(0, 1));
        pipe_rs1   = 5'($urandom_range(0, 31));
        pipe_addr  = 12'h7C0 + 12'($urandom_range(0, 3));
        pipe_wdata = $urandom();
    endtask

    // Architectural mstatus effects
    function automatic logic [31:0] model_trap_status(input logic [31:0] s);
        return (s & ~32'h0000_1888) | (((s >> 3) & 32'h1) << 7) | 32'h0000_1800;
    endfunction
    function automatic logic [31:0] model_mret_status(input logic [31:0] s);
        return (s & ~32'h0000_1888) | (((s >> 7) & 32'h1) << 3) | 32'h0000_0080;
    endfunction
    function automatic logic [31:0] model_vector(input logic [31:0] tvec, input logic [31:0] cause);
        logic [31:0] pc;
        pc = tvec & ~32'h3;
        if ((tvec % 4) == 1 && cause >= 32'h8000_0000)
            pc = pc + (cause - 32'h8000_0000) * 4;
        return pc;
    endfunction

    // Pipeline CSR access in IDLE; checks the port routing and write decision
    task automatic pipe_access(input logic [11:0] a, input logic [31:0] d,
                               input logic sc, input logic [4:0] rs1);
        logic exp_we;
        exp_we = !sc || (rs1 != 0);
        pipe_csr = 1; pipe_csrsc = sc; pipe_rs1 = rs1; pipe_addr = a; pipe_wdata = d;
        @(negedge clk);
        n_total++;
        if ({busy, csr_we, csr_addr, csr_wdata, pipe_rdata} !== {1'b0, exp_we, a, d, model_mem[a]})
            $display("FAIL pipe_access a=%h: got busy=%b we=%b addr=%h wd=%h rd=%h, want 0/%b/%h/%h/%h",
                     a, busy, csr_we, csr_addr, csr_wdata, pipe_rdata, exp_we, a, d, model_mem[a]);
        else n_pass++;
        next_cycle();
        pipe_csr = 0;
        if (exp_we) model_mem[a] = d;
    endtask

    // Full trap sequence with per-cycle checks; returns at the start of N+6
    task automatic do_trap(input logic [31:0] pc, input logic [31:0] cause,
                           input logic [31:0] val, input logic hold_mret);
        logic [31:0] exp_st, exp_rpc;
        logic [11:0] ea [0:3];
        logic [31:0] ed [0:3];
        exp_st  = model_trap_status(model_mem[12'h300]);
        exp_rpc = model_vector(model_mem[12'h305], cause);
        ea = '{12'h341, 12'h342, 12'h343, 12'h300};
        ed = '{pc, cause, val, exp_st};
        trap_req = 1; trap_pc = pc; trap_cause = cause; trap_val = val; mret_req = hold_mret;
        pipe_csr = 1; pipe_csrsc = 0; pipe_rs1 = 5'd3; pipe_addr = 12'h340; pipe_wdata = $urandom();
        @(negedge clk);
        n_total++;
        if ({busy, trap_ack, mret_ack, csr_we, redirect_valid} !== 5'b01000)
            $display("FAIL trap_accept: got busy/tack/mack/we/rv=%b%b%b%b%b want 01000",
                     busy, trap_ack, mret_ack, csr_we, redirect_valid);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            trap_req = 0; trap_pc = $urandom(); trap_cause = $urandom(); trap_val = $urandom();
            random_pipe();
            @(negedge clk);
            n_total++;
            if ({busy, csr_we, redirect_valid, trap_ack, mret_ack, csr_addr, csr_wdata, pipe_rdata}
                !== {5'b11000, ea[i], ed[i], 32'h0})
                $display("FAIL trap_write%0d: got b/we/rv/ta/ma=%b%b%b%b%b addr=%h wd=%h rd=%h want 11000 %h %h 0",
                         i, busy, csr_we, redirect_valid, trap_ack, mret_ack, csr_addr, csr_wdata,
                         pipe_rdata, ea[i], ed[i]);
            else n_pass++;
        end
        next_cycle();
        random_pipe();
        @(negedge clk);
        last_redirect = redirect_pc;
        n_total++;
        if ({busy, csr_we, redirect_valid, trap_ack, mret_ack, redirect_pc, pipe_rdata}
            !== {5'b10100, exp_rpc, 32'h0})
            $display("FAIL trap_redirect: got b/we/rv/ta/ma=%b%b%b%b%b pc=%h rd=%h want 10100 %h 0",
                     busy, csr_we, redirect_valid, trap_ack, mret_ack, redirect_pc, pipe_rdata, exp_rpc);
        else n_pass++;
        next_cycle();
        pipe_csr = 0;
        model_mem[12'h341] = pc; model_mem[12'h342] = cause;
        model_mem[12'h343] = val; model_mem[12'h300] = exp_st;
        if (!hold_mret) begin
            @(negedge clk);
            n_total++;
            if ({busy, redirect_valid, trap_ack, mret_ack, redirect_pc} !== {4'b0000, 32'h0})
                $display("FAIL trap_done: got b/rv/ta/ma=%b%b%b%b pc=%h want 0000 0",
                         busy, redirect_valid, trap_ack, mret_ack, redirect_pc);
            else n_pass++;
            next_cycle();
        end
    endtask

    // Full MRET sequence starting from a cycle where the DUT should be IDLE
    task automatic do_mret();
        logic [31:0] exp_st, exp_rpc;
        exp_st  = model_mret_status(model_mem[12'h300]);
        exp_rpc = model_mem[12'h341] & ~32'h3;
        mret_req = 1; trap_req = 0;
        pipe_csr = 1; pipe_csrsc = 0; pipe_rs1 = 5'd7; pipe_addr = 12'h340; pipe_wdata = $urandom();
        @(negedge clk);
        n_total++;
        if ({busy, mret_ack, trap_ack, csr_we, redirect_valid} !== 5'b01000)
            $display("FAIL mret_accept: got busy/mack/tack/we/rv=%b%b%b%b%b want 01000",
                     busy, mret_ack, trap_ack, csr_we, redirect_valid);
        else n_pass++;
        next_cycle();
        mret_req = 0;
        random_pipe();
        @(negedge clk);
        n_total++;
        if ({busy, csr_we, redirect_valid, mret_ack, csr_addr, csr_wdata, pipe_rdata}
            !== {4'b1100, 12'h300, exp_st, 32'h0})
            $display("FAIL mret_status: got b/we/rv/ma=%b%b%b%b addr=%h wd=%h rd=%h want 1100 300 %h 0",
                     busy, csr_we, redirect_valid, mret_ack, csr_addr, csr_wdata, pipe_rdata, exp_st);
        else n_pass++;
        next_cycle();
        random_pipe();
        @(negedge clk);
        last_redirect = redirect_pc;
        n_total++;
        if ({busy, csr_we, redirect_valid, redirect_pc} !== {3'b101, exp_rpc})
            $display("FAIL mret_redirect: got b/we/rv=%b%b%b pc=%h want 101 %h",
                     busy, csr_we, redirect_valid, redirect_pc, exp_rpc);
        else n_pass++;
        next_cycle();
        pipe_csr = 0;
        model_mem[12'h300] = exp_st;
        @(negedge clk);
        n_total++;
        if ({busy, redirect_valid, redirect_pc} !== {2'b00, 32'h0})
            $display("FAIL mret_done: got b/rv=%b%b pc=%h want 00 0", busy, redirect_valid, redirect_pc);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; trap_req = 1; mret_req = 1; trap_pc = 32'h44;
        pipe_csr = 1; pipe_addr = 12'h7C0; pipe_wdata = 32'h55;
        @(negedge clk);
        n_total++;
        if ({trap_ack, mret_ack, csr_we, redirect_valid} !== 4'b0000)
            $display("FAIL reset_gating: got tack/mack/we/rv=%b%b%b%b want 0000",
                     trap_ack, mret_ack, csr_we, redirect_valid);
        else n_pass++;
        next_cycle();
        next_cycle();
        rst = 0;
        idle_inputs();
        @(negedge clk);
        n_total++;
        if ({busy, trap_ack, mret_ack, redirect_valid, csr_we, redirect_pc} !== {5'b00000, 32'h0})
            $display("FAIL reset_state: got b/ta/ma/rv/we=%b%b%b%b%b pc=%h want 00000 0",
                     busy, trap_ack, mret_ack, redirect_valid, csr_we, redirect_pc);
        else n_pass++;
        n_total++;
        if (csr_mem[12'h7C0] !== 32'h0)
            $display("FAIL reset_no_write: got %h want 0", csr_mem[12'h7C0]);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_trap();
        pipe_access(12'h300, 32'h8,   1'b0, 5'd1);
        pipe_access(12'h305, 32'h100, 1'b0, 5'd1);
        do_trap(32'h200, 32'h2, 32'hDEAD, 1'b0);
        n_total++;
        if ({csr_mem[12'h341], csr_mem[12'h342], csr_mem[12'h343], csr_mem[12'h300], last_redirect}
            !== {32'h200, 32'h2, 32'hDEAD, 32'h1880, 32'h100})
            $display("FAIL trap_result: got epc=%h cause=%h tval=%h st=%h rpc=%h want 200 2 dead 1880 100",
                     csr_mem[12'h341], csr_mem[12'h342], csr_mem[12'h343], csr_mem[12'h300], last_redirect);
        else n_pass++;
    endtask

    task automatic test_vectored();
        pipe_access(12'h305, 32'h101, 1'b0, 5'd2);
        do_trap(32'h400, 32'h8000_0007, 32'h0, 1'b0);
        n_total++;
        if (last_redirect !== 32'h11C)
            $display("FAIL vectored_pc: got %h want 11c", last_redirect);
        else n_pass++;
    endtask

    task automatic test_mret();
        pipe_access(12'h300, 32'h1880, 1'b0, 5'd1);
        pipe_access(12'h341, 32'h203,  1'b0, 5'd1);
        do_mret();
        n_total++;
        if ({csr_mem[12'h300], last_redirect} !== {32'h88, 32'h200})
            $display("FAIL mret_result: got st=%h rpc=%h want 88 200", csr_mem[12'h300], last_redirect);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        pipe_access(12'h340, 32'h1234_5678, 1'b0, 5'd1);
        do_trap(32'h600, 32'h5, 32'hBEEF, 1'b1);   // mret held through the trap
        do_mret();                                 // must be accepted at N+6
        n_total++;
        if (csr_mem[12'h340] !== 32'h1234_5678)
            $display("FAIL mscratch_kept: got %h want 12345678", csr_mem[12'h340]);
        else n_pass++;
    endtask

    task automatic test_arbitration();
        pipe_access(12'h7C0, 32'hA5A5_0001, 1'b1, 5'd0);   // set/clear with x0: read only
        pipe_access(12'h7C1, 32'hA5A5_0002, 1'b1, 5'd9);   // set/clear with rs1: writes
        pipe_access(12'h7C0, 32'hA5A5_0003, 1'b0, 5'd0);   // plain write with x0: writes
        n_total++;
        if ({csr_mem[12'h7C0], csr_mem[12'h7C1]} !== {32'hA5A5_0003, 32'hA5A5_0002})
            $display("FAIL arb_result: got %h %h want a5a50003 a5a50002", csr_mem[12'h7C0], csr_mem[12'h7C1]);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] old_tval, old_st;
        int          bad;
        pipe_access(12'h300, 32'h8, 1'b0, 5'd1);
        old_tval = model_mem[12'h343];
        old_st   = model_mem[12'h300];
        trap_req = 1; trap_pc = 32'h900; trap_cause = 32'hB; trap_val = 32'hCAFE;
        next_cycle();                           // N accepted
        trap_req = 0;
        next_cycle();                           // N+1 T_EPC
        next_cycle();                           // N+2 T_CAUSE
        rst = 1;                                // N+3 T_TVAL
        @(negedge clk);
        n_total++;
        if ({csr_we, redirect_valid} !== 2'b00)
            $display("FAIL midreset_gate: got we/rv=%b%b want 00", csr_we, redirect_valid);
        else n_pass++;
        next_cycle();
        rst = 0;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0) $display("FAIL midreset_busy: got %b want 0", busy);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 7; i++) begin
            if (redirect_valid !== 1'b0 || busy !== 1'b0) bad++;
            next_cycle();
            @(negedge clk);
        end
        next_cycle();
        n_total++;
        if (bad != 0) $display("FAIL midreset_quiet: got %0d busy/redirect cycles want 0", bad);
        else n_pass++;
        model_mem[12'h341] = 32'h900;
        model_mem[12'h342] = 32'hB;
        n_total++;
        if ({csr_mem[12'h341], csr_mem[12'h342], csr_mem[12'h343], csr_mem[12'h300]}
            !== {32'h900, 32'hB, old_tval, old_st})
            $display("FAIL midreset_mem: got epc=%h cause=%h tval=%h st=%h want 900 b %h %h",
                     csr_mem[12'h341], csr_mem[12'h342], csr_mem[12'h343], csr_mem[12'h300],
                     old_tval, old_st);
        else n_pass++;
    endtask

    task automatic test_random();
        int          op;
        logic [31:0] cause;
        for (int it = 0; it < 40; it++) begin
            op = int'($urandom_range(0, 9));
            if (op <= 4) begin
                pipe_access(addr_set[$urandom_range(0, 9)], $urandom(),
                            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)));
            end else if (op == 5) begin
                pipe_access(12'h305, $urandom(), 1'b0, 5'd1);
            end else if (op <= 7) begin
                cause = ($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(0, 15));
                do_trap($urandom(), cause, $urandom(), 1'b0);
            end else begin
                do_mret();
            end
        end
    endtask

    task automatic test_memory();
        for (int i = 0; i < 10; i++) begin
            n_total++;
            if (csr_mem[addr_set[i]] !== model_mem[addr_set[i]])
                $display("FAIL mem_%h: got %h want %h", addr_set[i], csr_mem[addr_set[i]],
                         model_mem[addr_set[i]]);
            else n_pass++;
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) model_mem[i] = 32'h0;
        last_redirect = 32'h0;
        test_reset();
        test_trap();
        test_vectored();
        test_mret();
        test_back_to_back();
        test_arbitration();
        test_reset_mid();
        test_random();
        test_memory();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
`default_nettype wire
